// File: rtl/temp_trojan_seq.sv
// Temperature-triggered trojan: fires after HOLD_CNT consecutive hot samples and drives
// PATTERN onto the active-low seven-segment bus; optional hysteresis release when not sticky.
module temp_trojan_seq #(
    parameter int          TEMP_W   = 12,
    parameter int unsigned THRESH   = 3643,
    parameter int unsigned RELEASE  = 3700,
    parameter int          HOLD_CNT = 16,
    parameter bit          STICKY   = 1'b1,
    parameter logic [6:0]  PATTERN  = 7'b1001001,
    parameter logic [6:0]  BLANK    = 7'b1111111
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          arm,
    input  logic                          sample_valid,
    input  logic [TEMP_W-1:0]             temp,
    output logic [6:0]                    seven_seg,
    output logic                          triggered,
    output logic [$clog2(HOLD_CNT+1)-1:0] hot_cnt
);

    localparam int CNT_W = $clog2(HOLD_CNT + 1);
    localparam logic [TEMP_W-1:0] THRESH_C  = TEMP_W'(THRESH);
    localparam logic [TEMP_W-1:0] RELEASE_C = TEMP_W'(RELEASE);
    localparam logic [CNT_W-1:0]  HOLD_C    = CNT_W'(HOLD_CNT);
    localparam logic [CNT_W-1:0]  HOLD_M1   = CNT_W'(HOLD_CNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] hot_cnt_reg, hot_cnt_next;
    logic             triggered_reg;
    logic [6:0]       seven_seg_reg;

    logic is_hot;
    logic is_cool;

    // Code falls as temperature rises, so "hot" is the low end of the range.
    assign is_hot  = sample_valid && (temp <= THRESH_C);
    assign is_cool = sample_valid && (temp >= RELEASE_C);

    always_comb begin
        state_next   = state_reg;
        hot_cnt_next = hot_cnt_reg;
        if (!arm) begin
            state_next   = IDLE;
            hot_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next   = ARMED;
                    hot_cnt_next = '0;
                end
                ARMED: begin
                    if (is_hot) begin
                        if (hot_cnt_reg == HOLD_M1) begin
                            state_next   = FIRED;
                            hot_cnt_next = HOLD_C;
                        end else begin
                            hot_cnt_next = hot_cnt_reg + CNT_W'(1);
                        end
                    end else if (sample_valid) begin
                        hot_cnt_next = '0;
                    end
                end
                FIRED: begin
                    // Band codes between THRESH and RELEASE keep the trojan fired.
                    if (!STICKY && is_cool) begin
                        state_next   = ARMED;
                        hot_cnt_next = '0;
                    end else begin
                        hot_cnt_next = HOLD_C;
                    end
                end
                default: begin
                    state_next   = IDLE;
                    hot_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            hot_cnt_reg   <= '0;
            triggered_reg <= 1'b0;
            seven_seg_reg <= BLANK;
        end else begin
            state_reg     <= state_next;
            hot_cnt_reg   <= hot_cnt_next;
            triggered_reg <= (state_next == FIRED);
            seven_seg_reg <= (state_next == FIRED) ? PATTERN : BLANK;
        end
    end

    assign seven_seg = seven_seg_reg;
    assign triggered = triggered_reg;
    assign hot_cnt   = hot_cnt_reg;

endmodule
